// File: rtl/lift_look_ctrl.sv
// N-floor lift controller with LOOK scheduling.
// Floor requests are latched into a pending bitmap. The lift keeps moving in
// its current direction while requests lie ahead, and otherwise reverses.
// Each floor transit and each door stop is timed by one shared down-counter.
module lift_look_ctrl #(
  parameter int FLOORS      = 8,
  parameter int MOVE_CYCLES = 2,
  parameter int DOOR_CYCLES = 4,
  localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [FW-1:0]     req_floor,
  output logic              req_err,
  output logic [1:0]        dout,
  output logic [FW-1:0]     cur_floor,
  output logic              door_open,
  output logic [FLOORS-1:0] pending,
  output logic              done
);

  // The timer must hold the larger of the two reload values.
  localparam int TMAX = ((MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES) - 1;
  localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);
  localparam logic [FW:0]   FLOORS_W  = (FW + 1)'(FLOORS);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(FLOORS - 1);

  // Motion encoding shared with the motor driver.
  typedef enum logic [1:0] {
    MOT_UP   = 2'b00,
    MOT_DOWN = 2'b01,
    MOT_STAY = 2'b10
  } motion_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DOOR
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [FW-1:0]     r_cur_floor, w_cur_floor_nxt;
  logic              r_dir,       w_dir_nxt;     // 0 = up, 1 = down
  logic [FLOORS-1:0] r_pending,   w_pending_nxt;
  logic [TW-1:0]     r_timer,     w_timer_nxt;
  logic              r_req_err;

  logic          w_req_in_range;
  logic          w_req_ok;
  logic          w_req_here;
  logic          w_above;
  logic          w_below;
  logic          w_ahead;
  logic [FW-1:0] w_step_floor;
  logic          w_clr;
  logic [FW-1:0] w_clr_floor;

  assign w_req_in_range = ({1'b0, req_floor} < FLOORS_W);
  assign w_req_ok       = req_valid & w_req_in_range;
  assign w_req_here     = w_req_ok && (req_floor == r_cur_floor);
  assign w_step_floor   = r_dir ? (r_cur_floor - FW'(1)) : (r_cur_floor + FW'(1));

  // Work out where outstanding requests lie relative to the current floor and the next floor.
  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    w_ahead = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (r_pending[i] && (i > int'(r_cur_floor))) w_above = 1'b1;
      if (r_pending[i] && (i < int'(r_cur_floor))) w_below = 1'b1;
      if (r_pending[i] && (r_dir ? (i < int'(w_step_floor)) : (i > int'(w_step_floor))))
        w_ahead = 1'b1;
    end
  end

  // Next-state, timer, floor, direction and pending-bitmap update.
  always_comb begin
    // NOTE: every signal gets a default here, so no path through the case can leave one unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_cur_floor_nxt = r_cur_floor;
    w_dir_nxt       = r_dir;
    w_timer_nxt     = r_timer;
    w_clr           = 1'b0;
    w_clr_floor     = r_cur_floor;

    case (r_state)
      S_IDLE: begin
        if (r_pending[r_cur_floor]) begin
          w_state_nxt = S_DOOR;
          w_timer_nxt = DOOR_LOAD;
          w_clr       = 1'b1;
        end else if (w_above && (!r_dir || !w_below)) begin
          w_state_nxt = S_MOVE;
          w_dir_nxt   = 1'b0;
          w_timer_nxt = MOVE_LOAD;
        end else if (w_below) begin
          w_state_nxt = S_MOVE;
          w_dir_nxt   = 1'b1;
          w_timer_nxt = MOVE_LOAD;
        end
      end

      S_MOVE: begin
        if (r_timer == '0) begin
          w_cur_floor_nxt = w_step_floor;
          if (r_pending[w_step_floor]) begin
            w_state_nxt = S_DOOR;
            w_timer_nxt = DOOR_LOAD;
            w_clr       = 1'b1;
            w_clr_floor = w_step_floor;
          end else if (w_ahead) begin
            w_timer_nxt = MOVE_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end

      S_DOOR: begin
        // Requests for this floor never reach the bitmap while the door is open.
        w_clr = 1'b1;
        if (w_req_here) begin
          w_timer_nxt = DOOR_LOAD;
        end else if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Capture first, then clear, so that a clear on the same edge wins.
    w_pending_nxt = r_pending;
    if (w_req_ok) w_pending_nxt[req_floor] = 1'b1;
    if (w_clr)    w_pending_nxt[w_clr_floor] = 1'b0;
  end

  // State registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cur_floor <= '0;
      r_dir       <= 1'b0;
      r_pending   <= '0;
      r_timer     <= '0;
      r_req_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_floor <= w_cur_floor_nxt;
      r_dir       <= w_dir_nxt;
      r_pending   <= w_pending_nxt;
      r_timer     <= w_timer_nxt;
      r_req_err   <= req_valid & ~w_req_in_range;
    end
  end

  // Outputs are decoded from registered state only.
  assign dout      = (r_state == S_MOVE) ? (r_dir ? MOT_DOWN : MOT_UP) : MOT_STAY;
  assign cur_floor = r_cur_floor;
  assign door_open = (r_state == S_DOOR);
  assign pending   = r_pending;
  assign done      = (r_state == S_IDLE) && (r_pending == '0);
  assign req_err   = r_req_err;

  // The lift never drives the motor beyond the top or bottom floor.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!((dout == MOT_UP)   && (cur_floor == TOP_FLOOR)));
      assert (!((dout == MOT_DOWN) && (cur_floor == '0)));
    end
  end

endmodule

// File: tb/tb_lift_look_ctrl.sv
// Testbench for lift_look_ctrl: a cycle table for the single-request,
// current-floor and door-extension sequences, plus event-driven sequences for
// LOOK ordering, pass-through stops, mid-move reset and out-of-range requests.
module tb_lift_look_ctrl;

  localparam logic [1:0] UP = 2'b00;
  localparam logic [1:0] DN = 2'b01;
  localparam logic [1:0] ST = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_floor = '0;
  logic       req_err;
  logic [1:0] dout;
  logic [2:0] cur_floor;
  logic       door_open;
  logic [7:0] pending;
  logic       done;

  // Second instance with five floors, so the 3-bit request port can carry out-of-range floors.
  logic       s_req_valid = 1'b0;
  logic [2:0] s_req_floor = '0;
  logic       s_req_err;
  logic [1:0] s_dout;
  logic [2:0] s_cur_floor;
  logic       s_door_open;
  logic [4:0] s_pending;
  logic       s_done;

  always #5 clk = ~clk;

  lift_look_ctrl #(.FLOORS(8), .MOVE_CYCLES(2), .DOOR_CYCLES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .req_err   (req_err),
    .dout      (dout),
    .cur_floor (cur_floor),
    .door_open (door_open),
    .pending   (pending),
    .done      (done)
  );

  lift_look_ctrl #(.FLOORS(5), .MOVE_CYCLES(2), .DOOR_CYCLES(4)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (s_req_valid),
    .req_floor (s_req_floor),
    .req_err   (s_req_err),
    .dout      (s_dout),
    .cur_floor (s_cur_floor),
    .door_open (s_door_open),
    .pending   (s_pending),
    .done      (s_done)
  );

  typedef struct {
    logic       rst_n;
    logic       req_valid;
    logic [2:0] req_floor;
    logic [1:0] dout;
    logic [2:0] cur;
    logic       door;
    logic [7:0] pend;
    logic       done;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic v, input logic [2:0] f,
                              input logic [1:0] d, input logic [2:0] c, input logic o,
                              input logic [7:0] p, input logic dn);
    vec_t t;
    t.rst_n = r; t.req_valid = v; t.req_floor = f;
    t.dout = d; t.cur = c; t.door = o; t.pend = p; t.done = dn;
    tbl.push_back(t);
  endfunction

  // Issue one request, then run until the expected stops have been seen and the lift is done.
  // At the first UP sample on inj_at, a second request for inj_floor is injected.
  task automatic run_stops(input string name, input int first_floor, input int inj_at,
                           input int inj_floor, input int stop0, input int stop1,
                           input int up_exp, input int dn_exp);
    int   stops[$];
    int   up_n = 0;
    int   dn_n = 0;
    bit   injected = 0;
    logic prev_door = 1'b0;
    stops.push_back(stop0);
    stops.push_back(stop1);
    req_valid = 1'b1;
    req_floor = 3'(first_floor);
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      req_valid = 1'b0;
      if (dout == UP) up_n++;
      if (dout == DN) dn_n++;
      if (door_open && !prev_door) begin
        if (stops.size() > 0) check({name, " stop floor"}, 32'(cur_floor), 32'(stops.pop_front()));
        else                  check({name, " unexpected stop"}, 32'(cur_floor), 32'hFFFF);
      end
      prev_door = door_open;
      if (!injected && (int'(cur_floor) == inj_at) && (dout == UP)) begin
        req_valid = 1'b1;
        req_floor = 3'(inj_floor);
        injected  = 1;
      end
      if ((stops.size() == 0) && done) break;
    end
    check({name, " finished in budget"}, 32'((stops.size() == 0) && done), 32'd1);
    check({name, " UP cycles"},   32'(up_n), 32'(up_exp));
    check({name, " DOWN cycles"}, 32'(dn_n), 32'(dn_exp));
    check({name, " pending empty"}, 32'(pending), 32'd0);
  endtask

  initial begin
    // Reset for two edges, then request floor 3, descend to floor 2, and
    // exercise same-floor requests including door extension.
    add(0, 0, 0, ST, 0, 0, 8'h00, 1);
    add(0, 0, 0, ST, 0, 0, 8'h00, 1);
    add(1, 1, 3, ST, 0, 0, 8'h08, 0);  // edge 0: request latched
    add(1, 0, 0, UP, 0, 0, 8'h08, 0);  // edge 1: MOVE
    add(1, 0, 0, UP, 0, 0, 8'h08, 0);
    add(1, 0, 0, UP, 1, 0, 8'h08, 0);  // edge 3
    add(1, 0, 0, UP, 1, 0, 8'h08, 0);
    add(1, 0, 0, UP, 2, 0, 8'h08, 0);  // edge 5
    add(1, 0, 0, UP, 2, 0, 8'h08, 0);
    add(1, 0, 0, ST, 3, 1, 8'h00, 0);  // edge 7: DOOR
    add(1, 0, 0, ST, 3, 1, 8'h00, 0);
    add(1, 0, 0, ST, 3, 1, 8'h00, 0);
    add(1, 0, 0, ST, 3, 1, 8'h00, 0);
    add(1, 0, 0, ST, 3, 0, 8'h00, 1);  // edge 11: IDLE
    add(1, 0, 0, ST, 3, 0, 8'h00, 1);
    add(1, 1, 2, ST, 3, 0, 8'h04, 0);  // request floor 2 from floor 3
    add(1, 0, 0, DN, 3, 0, 8'h04, 0);
    add(1, 0, 0, DN, 3, 0, 8'h04, 0);
    add(1, 0, 0, ST, 2, 1, 8'h00, 0);
    add(1, 0, 0, ST, 2, 1, 8'h00, 0);
    add(1, 0, 0, ST, 2, 1, 8'h00, 0);
    add(1, 0, 0, ST, 2, 1, 8'h00, 0);
    add(1, 0, 0, ST, 2, 0, 8'h00, 1);
    add(1, 1, 2, ST, 2, 0, 8'h04, 0);  // same-floor request while IDLE
    add(1, 1, 2, ST, 2, 1, 8'h00, 0);  // DOOR entry; concurrent request absorbed
    add(1, 1, 2, ST, 2, 1, 8'h00, 0);  // door timer reloads
    add(1, 1, 2, ST, 2, 1, 8'h00, 0);  // last request
    add(1, 0, 0, ST, 2, 1, 8'h00, 0);
    add(1, 0, 0, ST, 2, 1, 8'h00, 0);
    add(1, 0, 0, ST, 2, 1, 8'h00, 0);
    add(1, 0, 0, ST, 2, 0, 8'h00, 1);  // four cycles after the last request: IDLE

    foreach (tbl[i]) begin
      vec_t e;
      rst_n     = tbl[i].rst_n;
      req_valid = tbl[i].req_valid;
      req_floor = tbl[i].req_floor;
      exp_q.push_back(tbl[i]);
      tick();
      e = exp_q.pop_front();
      check($sformatf("v%0d dout", i),      32'(dout),      32'(e.dout));
      check($sformatf("v%0d cur_floor", i), 32'(cur_floor), 32'(e.cur));
      check($sformatf("v%0d door_open", i), 32'(door_open), 32'(e.door));
      check($sformatf("v%0d pending", i),   32'(pending),   32'(e.pend));
      check($sformatf("v%0d done", i),      32'(done),      32'(e.done));
    end
    req_valid = 1'b0;

    // LOOK ordering: from floor 2, request 6; at floor 4 going up, add 1. Serve 6 first, then 1.
    run_stops("look", 6, 4, 1, 6, 1, 8, 10);

    // Reset in the middle of a MOVE toward floor 7.
    req_valid = 1'b1;
    req_floor = 3'd7;
    tick();
    req_valid = 1'b0;
    begin
      bit hit = 0;
      for (int c = 0; c < 100; c++) begin
        tick();
        if ((cur_floor == 3'd3) && (dout == UP)) begin
          hit = 1;
          break;
        end
      end
      check("reset: reached mid-move", 32'(hit), 32'd1);
    end
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("reset%0d cur_floor", k), 32'(cur_floor), 32'd0);
      check($sformatf("reset%0d pending", k),   32'(pending),   32'd0);
      check($sformatf("reset%0d dout", k),      32'(dout),      32'(ST));
      check($sformatf("reset%0d done", k),      32'(done),      32'd1);
      check($sformatf("reset%0d door_open", k), 32'(door_open), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("post-reset dout", 32'(dout), 32'(ST));
    check("post-reset done", 32'(done), 32'd1);

    // Pass-through: moving up from 0 to 5; request 3 while at floor 1. Stop at 3, then 5.
    run_stops("pass", 5, 1, 3, 3, 5, 10, 0);

    // Out-of-range and duplicate requests on the five-floor instance.
    s_req_valid = 1'b1; s_req_floor = 3'd6;
    tick();
    check("oor6 req_err", 32'(s_req_err), 32'd1);
    check("oor6 pending", 32'(s_pending), 32'd0);
    check("oor6 done",    32'(s_done),    32'd1);
    s_req_valid = 1'b0;
    tick();
    check("oor pulse ends", 32'(s_req_err), 32'd0);
    check("oor state kept", 32'(s_dout),    32'(ST));
    check("oor done kept",  32'(s_done),    32'd1);
    s_req_floor = 3'd7;  // not valid: must not flag an error
    tick();
    check("invalid oor no err", 32'(s_req_err), 32'd0);
    s_req_valid = 1'b1; s_req_floor = 3'd7;
    tick();
    check("oor7 req_err", 32'(s_req_err), 32'd1);
    s_req_floor = 3'd4;
    tick();
    check("top req_err",  32'(s_req_err), 32'd0);
    check("top pending",  32'(s_pending), 32'h10);
    tick();
    check("dup pending",  32'(s_pending), 32'h10);
    check("dup departs",  32'(s_dout),    32'(UP));
    s_req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
